alu_muldiv_seq: RTL and testbench

Iterative multiply/divide unit implementing the RV32M operations, parametrised in operand width. It sits beside the single-cycle integer ALU in the execute stage and is used when the core moves to multi-cycle M-extension support. It computes one bit per cycle with a shift-add multiplier and a restoring divider behind a valid/ready handshake. Like the ALU, it reports a zero flag alongside the result.

---
 rtl/alu_muldiv_pkg.sv | 37 +++
 rtl/alu_muldiv_seq_if.sv | 27 ++
 rtl/muldiv_datapath.sv | 54 +++++
 rtl/alu_muldiv_seq.sv | 137 +++++++++++++
 tb/tb_alu_muldiv_seq.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared types and op decode helpers for the iterative RV32M multiply/divide unit.
// Pure declarations, no latency.
// No backpressure; consumers only.
package alu_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_e;

    function automatic logic is_div(input op_e op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// Wires only, no latency.
// valid/ready on both request and result sides; flush kills the in-flight op.
interface alu_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, op, src_a, src_b, flush, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op, src_a, src_b, flush, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Shared hi/lo accumulator: shift-add multiply or restoring divide, one bit per step.
// One register update per step; load takes one cycle.
// No handshake; the controlling FSM sequences load/step.
module muldiv_datapath
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            div_mode,
    input  logic [XLEN-1:0] load_lo,
    input  logic [XLEN-1:0] load_opnd,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    logic [XLEN-1:0] opnd;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   add;
    logic [XLEN-1:0] shl;
    logic [XLEN-1:0] diff;
    logic            fits;

    // hi[XLEN-1] is the bit shifted out of the remainder; when set the subtract always fits
    always_comb begin
        sum  = {1'b0, hi} + {1'b0, opnd};
        add  = lo[0] ? sum : {1'b0, hi};
        shl  = {hi[XLEN-2:0], lo[XLEN-1]};
        fits = hi[XLEN-1] | (shl >= opnd);
        diff = shl - opnd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
        end else if (load) begin
            hi   <= '0;
            lo   <= load_lo;
            opnd <= load_opnd;
        end else if (step) begin
            if (div_mode) begin
                hi <= fits ? diff : shl;
                lo <= {lo[XLEN-2:0], fits};
            end else begin
                hi <= add[XLEN:1];
                lo <= {add[0], lo[XLEN-1:1]};
            end
        end
    end
endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit with zero flag.
// XLEN+2 cycles accept-to-result (1 for divide-by-zero / signed overflow).
// Single op in flight; result held until out_ready, flush or reset discards it.
module alu_muldiv_seq
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic             clk,
    input logic             rst_n,
    alu_muldiv_seq_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state;
    op_e             op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            neg_q;
    logic            neg_r;
    logic [CNT_W-1:0] cnt;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;

    logic            sa;
    logic            sb;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] dp_hi;
    logic [XLEN-1:0] dp_lo;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] fix_res;

    always_comb begin
        sa       = is_signed_a(op_q) & a_q[XLEN-1];
        sb       = is_signed_b(op_q) & b_q[XLEN-1];
        mag_a    = sa ? -a_q : a_q;
        mag_b    = sb ? -b_q : b_q;
        div_zero = is_div(op_q) && (b_q == '0);
        div_ovf  = is_div(op_q) && is_signed_a(op_q) && (a_q == MIN_NEG) && (b_q == '1);
        // op[1] selects remainder among the divide ops
        if (op_q[1]) special_res = div_zero ? a_q : '0;
        else         special_res = div_zero ? '1  : a_q;
    end

    muldiv_datapath #(.XLEN(XLEN)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (state == ST_PREP),
        .step      (state == ST_CALC),
        .div_mode  (is_div(op_q)),
        .load_lo   (is_div(op_q) ? mag_a : mag_b),
        .load_opnd (is_div(op_q) ? mag_b : mag_a),
        .hi        (dp_hi),
        .lo        (dp_lo)
    );

    always_comb begin
        prod_s = neg_q ? -{dp_hi, dp_lo} : {dp_hi, dp_lo};
        case (op_q)
            OP_MUL:                     fix_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            fix_res = neg_q ? -dp_lo : dp_lo;
            default:                    fix_res = neg_r ? -dp_hi : dp_hi;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_q        <= OP_MUL;
            a_q         <= '0;
            b_q         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
        end else if (bus.flush && state != ST_IDLE) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) begin
                    op_q       <= op_e'(bus.op);
                    a_q        <= bus.src_a;
                    b_q        <= bus.src_b;
                    in_ready_q <= 1'b0;
                    state      <= ST_PREP;
                end
                ST_PREP: begin
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    if (div_zero || div_ovf) begin
                        result_q    <= special_res;
                        zero_q      <= (special_res == '0);
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        cnt   <= CNT_W'(XLEN);
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    result_q    <= fix_res;
                    zero_q      <= (fix_res == '0);
                    out_valid_q <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq at XLEN=32: arithmetic, specials, backpressure, kill paths.
module tb_alu_muldiv_seq;
    import alu_muldiv_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_muldiv_seq_if #(.XLEN(XLEN)) bus ();

    alu_muldiv_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Issue one op, wait (bounded) for the result, then consume it.
    task automatic drive_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] r, output logic z, output int lat);
        @(negedge clk);
        bus.op = o; bus.src_a = a; bus.src_b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.out_valid && lat < 100);
        r = bus.result;
        z = bus.zero;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", bus.zero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] r; logic z; int lat;
        drive_op(OP_MUL, 32'd7, 32'hFFFFFFFD, r, z, lat);
        checks++; if (r !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result got %h exp ffffffeb", r); end
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL mul_zero got %b exp 0", z); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL mul_latency got %0d exp 34", lat); end
    endtask

    task automatic test_mulh();
        logic [31:0] r; logic z; int lat;
        drive_op(OP_MULH, 32'h80000000, 32'h80000000, r, z, lat);
        checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL mulh_result got %h exp 40000000", r); end
        drive_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, z, lat);
        checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu_result got %h exp fffffffe", r); end
        drive_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, z, lat);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu_result got %h exp ffffffff", r); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL mulhsu_latency got %0d exp 34", lat); end
    endtask

    task automatic test_div();
        logic [31:0] r; logic z; int lat;
        drive_op(OP_DIV, 32'hFFFFFFF9, 32'd2, r, z, lat);
        checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_result got %h exp fffffffd", r); end
        drive_op(OP_REM, 32'hFFFFFFF9, 32'd2, r, z, lat);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_result got %h exp ffffffff", r); end
        drive_op(OP_DIVU, 32'd100, 32'd7, r, z, lat);
        checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_result got %h exp 0000000e", r); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL divu_latency got %0d exp 34", lat); end
        drive_op(OP_REMU, 32'd100, 32'd7, r, z, lat);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_result got %h exp 00000002", r); end
    endtask

    task automatic test_special();
        logic [31:0] r; logic z; int lat;
        drive_op(OP_DIV, 32'd5, 32'd0, r, z, lat);
        checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_result got %h exp ffffffff", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency got %0d exp 1", lat); end
        drive_op(OP_REMU, 32'd5, 32'd0, r, z, lat);
        checks++; if (r !== 32'd5) begin errors++; $display("FAIL remu0_result got %h exp 00000005", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL remu0_latency got %0d exp 1", lat); end
        drive_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, r, z, lat);
        checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL divovf_result got %h exp 80000000", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL divovf_latency got %0d exp 1", lat); end
        drive_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, r, z, lat);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL removf_result got %h exp 00000000", r); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL removf_zero got %b exp 1", z); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL removf_latency got %0d exp 1", lat); end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; logic z; int lat;
        @(negedge clk);
        bus.op = OP_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.out_valid && lat < 100);
        checks++; if (lat !== 34) begin errors++; $display("FAIL bp_latency got %0d exp 34", lat); end
        bus.op = OP_MUL; bus.src_a = 32'd5; bus.src_b = 32'd5; bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.result !== 32'd14 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                begin errors++; $display("FAIL bp_hold cycle %0d got res=%h vld=%b rdy=%b exp res=0000000e vld=1 rdy=0",
                                         i, bus.result, bus.out_valid, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0", bus.in_ready, bus.out_valid); end
        drive_op(OP_MUL, 32'd3, 32'd3, r, z, lat);
        checks++; if (r !== 32'd9) begin errors++; $display("FAIL bp_next_result got %h exp 00000009", r); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL bp_next_latency got %0d exp 34", lat); end
    endtask

    task automatic test_flush();
        logic [31:0] r; logic z; int lat;
        int seen;
        @(negedge clk);
        bus.op = OP_DIVU; bus.src_a = 32'd1000; bus.src_b = 32'd3; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL flush_idle got rdy=%b vld=%b exp rdy=1 vld=0", bus.in_ready, bus.out_valid); end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_valid got %0d valid cycles exp 0", seen); end
        drive_op(OP_MULHU, 32'h00010000, 32'h00030000, r, z, lat);
        checks++; if (r !== 32'd3) begin errors++; $display("FAIL flush_next_result got %h exp 00000003", r); end
    endtask

    task automatic test_midop_reset();
        int seen;
        @(negedge clk);
        bus.op = OP_MUL; bus.src_a = 32'd12345; bus.src_b = 32'd678; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b exp 1", bus.in_ready); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL rst_mid_result got %h exp 0", bus.result); end
        checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL rst_mid_zero got %b exp 1", bus.zero); end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_valid got %0d valid cycles exp 0", seen); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.op = 3'b000; bus.src_a = '0; bus.src_b = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_midop_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
